// File: rtl/rr_req_initiator.sv
// rr_req_initiator: per-master crossbar request controller with routed-ack wait and timeout
module rr_req_initiator #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              master_req,
  input  logic [ADDR_W-1:0] master_addr,
  input  logic              master_cmd,
  input  logic [DATA_W-1:0] master_wdata,
  output logic              master_ack,
  output logic              master_err,
  output logic [DATA_W-1:0] master_rdata,
  output logic              sfor,
  output logic [1:0]        req_stat,
  output logic              s_req,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_cmd,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              gnt,
  input  logic              ack,
  input  logic [DATA_W-1:0] s_rdata
);
  typedef enum logic [1:0] {IDLE = 2'd0, W_GNT = 2'd1, W_ACK = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_n;
  logic [7:0] timer;
  logic expire;
  assign expire = timer == 8'(TIMEOUT - 1);
  assign master_ack = state == DONE;
  assign s_req = state == W_GNT;
  assign req_stat = state;
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (master_req ? W_GNT : IDLE) :
              state == W_GNT ? (gnt ? W_ACK : W_GNT) :
              state == W_ACK ? ((ack || expire) ? DONE : W_ACK) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      sfor         <= 1'b0;
      s_addr       <= '0;
      s_cmd        <= 1'b0;
      s_wdata      <= '0;
      master_err   <= 1'b0;
      master_rdata <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (master_req) begin
          s_addr       <= master_addr;
          s_cmd        <= master_cmd;
          s_wdata      <= master_wdata;
          sfor         <= master_addr[ADDR_W-1];
          master_err   <= 1'b0;
          master_rdata <= '0;
        end
        W_GNT: if (gnt) timer <= '0;
        W_ACK: begin
          timer <= timer + 8'd1;
          if (ack) begin
            if (!s_cmd) master_rdata <= s_rdata;
            master_err <= 1'b0;
          end else if (expire) begin
            master_err   <= 1'b1;
            master_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_req_initiator.sv
// tb_rr_req_initiator: scoreboard bench for rr_req_initiator
module tb_rr_req_initiator;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        master_req = 1'b0;
  logic [31:0] master_addr = '0;
  logic        master_cmd = 1'b0;
  logic [31:0] master_wdata = '0;
  logic        master_ack, master_err, sfor, s_req, s_cmd;
  logic [31:0] master_rdata, s_addr, s_wdata;
  logic [1:0]  req_stat;
  logic        gnt = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] s_rdata = '0;
  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  exp_t sb[$];
  exp_t e;
  int vectors = 0;
  int miscompares = 0;
  rr_req_initiator dut (
    .clk(clk), .reset(reset), .master_req(master_req), .master_addr(master_addr),
    .master_cmd(master_cmd), .master_wdata(master_wdata), .master_ack(master_ack),
    .master_err(master_err), .master_rdata(master_rdata), .sfor(sfor), .req_stat(req_stat),
    .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata), .gnt(gnt), .ack(ack),
    .s_rdata(s_rdata)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (req_stat !== 2'd0 || s_req !== 1'b0 || master_ack !== 1'b0 || sfor !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got stat=%0d s_req=%b ack=%b sfor=%b, want 0 0 0 0", req_stat, s_req, master_ack, sfor);
    end
    vectors++;
    if (s_addr !== 32'd0 || s_cmd !== 1'b0 || s_wdata !== 32'd0 || master_err !== 1'b0 || master_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_data: got addr=%h cmd=%b wdata=%h err=%b rdata=%h, want zeros", s_addr, s_cmd, s_wdata, master_err, master_rdata);
    end
    reset = 1'b0;
    tick();
  endtask
  task automatic test_write();
    master_req = 1'b1; master_addr = 32'h8000_0010; master_cmd = 1'b1; master_wdata = 32'hDEADBEEF;
    sb.push_back('{32'd0, 1'b0});
    vectors++;
    if (req_stat !== 2'd0) begin miscompares++; $display("FAIL wr_idle: got stat=%0d want 0", req_stat); end
    tick();
    vectors++;
    if (req_stat !== 2'd1 || s_req !== 1'b1 || sfor !== 1'b1 || s_wdata !== 32'hDEADBEEF || s_addr !== 32'h8000_0010 || s_cmd !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_wgnt: got stat=%0d s_req=%b sfor=%b wdata=%h addr=%h cmd=%b", req_stat, s_req, sfor, s_wdata, s_addr, s_cmd);
    end
    tick();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    vectors++;
    if (req_stat !== 2'd2 || s_req !== 1'b0) begin miscompares++; $display("FAIL wr_wack: got stat=%0d s_req=%b want 2 0", req_stat, s_req); end
    tick();
    tick();
    ack = 1'b1;
    s_rdata = 32'h5555_AAAA;
    tick();
    ack = 1'b0;
    vectors++;
    if (req_stat !== 2'd3 || master_ack !== 1'b1 || sfor !== 1'b1 || s_wdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL wr_done: got stat=%0d ack=%b sfor=%b wdata=%h", req_stat, master_ack, sfor, s_wdata);
    end
    if (master_ack === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (master_rdata !== e.rdata || master_err !== e.err) begin
        miscompares++;
        $display("FAIL wr_result: got rdata=%h err=%b want %h %b", master_rdata, master_err, e.rdata, e.err);
      end
    end
    master_req = 1'b0;
    tick();
    vectors++;
    if (req_stat !== 2'd0 || master_ack !== 1'b0) begin miscompares++; $display("FAIL wr_pulse: got stat=%0d ack=%b want 0 0", req_stat, master_ack); end
  endtask
  task automatic test_read();
    int n;
    master_req = 1'b1; master_addr = 32'h0000_0004; master_cmd = 1'b0; master_wdata = 32'h0;
    gnt = 1'b1;
    sb.push_back('{32'h12345678, 1'b0});
    tick();
    vectors++;
    if (sfor !== 1'b0 || req_stat !== 2'd1) begin miscompares++; $display("FAIL rd_sfor: got sfor=%b stat=%0d want 0 1", sfor, req_stat); end
    tick();
    gnt = 1'b0;
    ack = 1'b1;
    s_rdata = 32'h12345678;
    n = 0;
    tick();
    ack = 1'b0;
    while (master_ack !== 1'b1 && n < 20) begin tick(); n++; end
    vectors++;
    if (master_ack !== 1'b1) begin miscompares++; $display("FAIL rd_ack: got no master_ack within %0d cycles", n); end
    else begin
      e = sb.pop_front();
      vectors++;
      if (master_rdata !== e.rdata || master_err !== e.err) begin
        miscompares++;
        $display("FAIL rd_result: got rdata=%h err=%b want %h %b", master_rdata, master_err, e.rdata, e.err);
      end
    end
    master_req = 1'b0;
    tick();
    vectors++;
    if (master_rdata !== 32'h12345678) begin miscompares++; $display("FAIL rd_hold: got rdata=%h want 12345678", master_rdata); end
  endtask
  task automatic test_timeout();
    master_req = 1'b1; master_addr = 32'h0000_0008; master_cmd = 1'b0;
    gnt = 1'b1;
    sb.push_back('{32'd0, 1'b1});
    tick();
    tick();
    gnt = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    vectors++;
    if (req_stat !== 2'd2) begin miscompares++; $display("FAIL to_early: got stat=%0d at W_ACK cycle 15, want 2", req_stat); end
    tick();
    vectors++;
    if (master_ack !== 1'b1 || req_stat !== 2'd3) begin miscompares++; $display("FAIL to_done: got ack=%b stat=%0d want 1 3", master_ack, req_stat); end
    else begin
      e = sb.pop_front();
      vectors++;
      if (master_rdata !== e.rdata || master_err !== e.err) begin
        miscompares++;
        $display("FAIL to_result: got rdata=%h err=%b want %h %b", master_rdata, master_err, e.rdata, e.err);
      end
    end
    master_req = 1'b0;
    tick();
    ack = 1'b1;
    s_rdata = 32'hBAD0_BAD0;
    tick();
    ack = 1'b0;
    tick();
    vectors++;
    if (req_stat !== 2'd0 || master_ack !== 1'b0 || master_err !== 1'b1 || master_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL to_late_ack: got stat=%0d ack=%b err=%b rdata=%h want 0 0 1 0", req_stat, master_ack, master_err, master_rdata);
    end
  endtask
  task automatic test_coincide();
    master_req = 1'b1; master_addr = 32'h0000_0020; master_cmd = 1'b0;
    gnt = 1'b1;
    sb.push_back('{32'hCAFEF00D, 1'b0});
    tick();
    tick();
    gnt = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    ack = 1'b1;
    s_rdata = 32'hCAFEF00D;
    tick();
    ack = 1'b0;
    vectors++;
    if (master_ack !== 1'b1) begin miscompares++; $display("FAIL co_ack: got ack=%b want 1", master_ack); end
    else begin
      e = sb.pop_front();
      vectors++;
      if (master_rdata !== e.rdata || master_err !== e.err) begin
        miscompares++;
        $display("FAIL co_result: got rdata=%h err=%b want %h %b", master_rdata, master_err, e.rdata, e.err);
      end
    end
    master_req = 1'b0;
    tick();
  endtask
  task automatic test_reset_mid();
    master_req = 1'b1; master_addr = 32'h8000_0040; master_cmd = 1'b1; master_wdata = 32'h0BAD_F00D;
    gnt = 1'b1;
    tick();
    tick();
    gnt = 1'b0;
    tick();
    reset = 1'b1;
    master_req = 1'b0;
    tick();
    reset = 1'b0;
    vectors++;
    if (req_stat !== 2'd0 || s_req !== 1'b0 || master_ack !== 1'b0 || sfor !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_state: got stat=%0d s_req=%b ack=%b sfor=%b want 0 0 0 0", req_stat, s_req, master_ack, sfor);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    vectors++;
    if (req_stat !== 2'd0 || master_ack !== 1'b0) begin miscompares++; $display("FAIL rm_stale: got stat=%0d ack=%b want 0 0", req_stat, master_ack); end
  endtask
  task automatic test_back_to_back();
    int acks = 0;
    master_req = 1'b1; master_addr = 32'h0000_0100; master_cmd = 1'b0;
    gnt = 1'b1; ack = 1'b1; s_rdata = 32'h1111_1111;
    sb.push_back('{32'h1111_1111, 1'b0});
    sb.push_back('{32'h2222_2222, 1'b0});
    tick();
    vectors++;
    if (sfor !== 1'b0 || req_stat !== 2'd1) begin miscompares++; $display("FAIL bb_first: got sfor=%b stat=%0d want 0 1", sfor, req_stat); end
    tick();
    tick();
    if (master_ack === 1'b1) begin
      acks++;
      e = sb.pop_front();
      vectors++;
      if (master_rdata !== e.rdata || master_err !== e.err) begin
        miscompares++;
        $display("FAIL bb_res1: got rdata=%h err=%b want %h %b", master_rdata, master_err, e.rdata, e.err);
      end
    end
    master_addr = 32'h8000_0200;
    s_rdata = 32'h2222_2222;
    tick();
    vectors++;
    if (req_stat !== 2'd0) begin miscompares++; $display("FAIL bb_idle: got stat=%0d want 0", req_stat); end
    tick();
    vectors++;
    if (sfor !== 1'b1 || req_stat !== 2'd1 || s_addr !== 32'h8000_0200) begin
      miscompares++;
      $display("FAIL bb_second: got sfor=%b stat=%0d addr=%h want 1 1 80000200", sfor, req_stat, s_addr);
    end
    tick();
    tick();
    master_req = 1'b0;
    if (master_ack === 1'b1) begin
      acks++;
      e = sb.pop_front();
      vectors++;
      if (master_rdata !== e.rdata || master_err !== e.err) begin
        miscompares++;
        $display("FAIL bb_res2: got rdata=%h err=%b want %h %b", master_rdata, master_err, e.rdata, e.err);
      end
    end
    gnt = 1'b0; ack = 1'b0;
    vectors++;
    if (acks != 2) begin miscompares++; $display("FAIL bb_count: got %0d master_ack pulses want 2", acks); end
    tick();
  endtask
  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_coincide();
    test_reset_mid();
    test_back_to_back();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL sb_empty: got %0d pending results want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
